// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, clocking constants and the byte type.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned CLK_FREQ    = 50_000_000;
    localparam int unsigned BAUDRATE    = 115_200;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with a sticky overflow
// flag and a saturating framing-error counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_W    = UART_DATA_W,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_ferr,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [ERR_CNT_W-1:0]       ferr_count,
    input  logic                       clear_flags
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              push;
    logic              pop;
    logic              do_write;

    // Extra pointer MSB separates full from empty; modulo subtraction gives occupancy.
    assign level    = wr_ptr - rd_ptr;
    assign m_valid  = (wr_ptr != rd_ptr);
    assign full     = (level == PW'(DEPTH));
    assign push     = rx_valid & ~rx_ferr;
    assign pop      = m_valid & m_ready;
    assign do_write = push & (~full | pop);
    assign m_data   = m_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // New events take priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push & full & ~pop) begin
            overflow <= 1'b1;
        end else if (clear_flags) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_count <= '0;
        end else if (rx_ferr) begin
            if (clear_flags) begin
                ferr_count <= ERR_CNT_W'(1);
            end else if (ferr_count != '1) begin
                ferr_count <= ferr_count + ERR_CNT_W'(1);
            end
        end else if (clear_flags) begin
            ferr_count <= '0;
        end
    end

endmodule
